// File: rtl/btn_counter_pkg.sv
// ============================================================================
// Package : btn_counter_pkg
// Brief   : Shared debounce state encoding and counter widths for the
//           push-button step counter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package btn_counter_pkg;

    localparam int DEB_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_t;

endpackage : btn_counter_pkg

`default_nettype wire

// File: rtl/btn_pulse_gen.sv
// ============================================================================
// Module : btn_pulse_gen
// Brief  : Two-flop synchroniser plus tick-driven debounce FSM; emits a
//          one-clock load pulse per accepted button press.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_pulse_gen
    import btn_counter_pkg::*;
#(
    parameter int DEB_TICKS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic btn_in,
    output logic load
);

    localparam logic [DEB_CNT_W-1:0] c_DEB_TICKS = DEB_CNT_W'(DEB_TICKS);
    localparam logic [DEB_CNT_W-1:0] c_ONE       = DEB_CNT_W'(1);

    logic                 r_sync1;
    logic                 r_sync2;
    deb_state_t           r_state;
    deb_state_t           w_state_nxt;
    logic [DEB_CNT_W-1:0] r_deb_cnt;
    logic [DEB_CNT_W-1:0] w_deb_cnt_nxt;
    logic [DEB_CNT_W-1:0] w_deb_cnt_inc;
    logic                 r_load;
    logic                 w_load_nxt;

    assign w_deb_cnt_inc = r_deb_cnt + c_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_deb_cnt <= '0;
            r_load    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_deb_cnt <= w_deb_cnt_nxt;
            r_load    <= w_load_nxt;
        end
    end

    // Any sample that disagrees with the level being qualified restarts the run.
    always_comb begin
        w_state_nxt   = r_state;
        w_deb_cnt_nxt = r_deb_cnt;
        w_load_nxt    = 1'b0;
        if (tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_sync2) begin
                        if (c_DEB_TICKS == c_ONE) begin
                            w_state_nxt   = ST_PRESSED;
                            w_deb_cnt_nxt = '0;
                            w_load_nxt    = 1'b1;
                        end else begin
                            w_state_nxt   = ST_PRESS_WAIT;
                            w_deb_cnt_nxt = c_ONE;
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!r_sync2) begin
                        w_state_nxt   = ST_IDLE;
                        w_deb_cnt_nxt = '0;
                    end else if (w_deb_cnt_inc == c_DEB_TICKS) begin
                        w_state_nxt   = ST_PRESSED;
                        w_deb_cnt_nxt = '0;
                        w_load_nxt    = 1'b1;
                    end else begin
                        w_deb_cnt_nxt = w_deb_cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (!r_sync2) begin
                        if (c_DEB_TICKS == c_ONE) begin
                            w_state_nxt   = ST_IDLE;
                            w_deb_cnt_nxt = '0;
                        end else begin
                            w_state_nxt   = ST_RELEASE_WAIT;
                            w_deb_cnt_nxt = c_ONE;
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (r_sync2) begin
                        w_state_nxt   = ST_PRESSED;
                        w_deb_cnt_nxt = '0;
                    end else if (w_deb_cnt_inc == c_DEB_TICKS) begin
                        w_state_nxt   = ST_IDLE;
                        w_deb_cnt_nxt = '0;
                    end else begin
                        w_deb_cnt_nxt = w_deb_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt   = ST_IDLE;
                    w_deb_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign load = r_load;

endmodule : btn_pulse_gen

`default_nettype wire

// File: rtl/btn_step_counter.sv
// ============================================================================
// Module : btn_step_counter
// Brief  : Up/down step counter advanced by a debounced push-button, with
//          wrap pulse. Define BTN_CNT_SAT_EN for saturating instead of modular.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_step_counter
    import btn_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int DEB_TICKS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             btn_in,
    input  logic             dir,
    input  logic             clr,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_next,
    output logic             load,
    output logic             wrap
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             w_load;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_next;

    btn_pulse_gen #(
        .DEB_TICKS (DEB_TICKS)
    ) u_pulse_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .btn_in (btn_in),
        .load   (w_load)
    );

    // The extra top bit carries out on up-count and borrows on down-count.
    assign w_sum  = {1'b0, r_cnt} + {1'b0, step};
    assign w_diff = {1'b0, r_cnt} - {1'b0, step};
    assign w_ovf  = dir ? w_diff[WIDTH] : w_sum[WIDTH];

    always_comb begin
        w_res = dir ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];
`ifdef BTN_CNT_SAT_EN
        if (w_ovf) begin
            w_res = dir ? '0 : '1;
        end
`endif
    end

    assign w_next = clr ? '0 : w_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wrap <= 1'b0;
        end else if (w_load) begin
            r_cnt  <= w_next;
            r_wrap <= w_ovf & ~clr;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign cnt      = r_cnt;
    assign cnt_next = w_next;
    assign load     = w_load;
    assign wrap     = r_wrap;

endmodule : btn_step_counter

`default_nettype wire

// File: tb/tb_btn_step_counter.sv
// ============================================================================
// Module : tb_btn_step_counter
// Brief  : Scoreboard bench for btn_step_counter (WIDTH=4, DEB_TICKS=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_btn_step_counter;
    import btn_counter_pkg::*;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         wrap;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         tick;
    logic         btn_in;
    logic         dir;
    logic         clr;
    logic [W-1:0] step;
    logic [W-1:0] cnt;
    logic [W-1:0] cnt_next;
    logic         load;
    logic         wrap;

    exp_t exp_q[$];
    exp_t pend;
    logic armed;
    int   n_cmp;
    int   n_err;
    int   n_loads;

    btn_step_counter #(
        .WIDTH     (W),
        .DEB_TICKS (4)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .btn_in   (btn_in),
        .dir      (dir),
        .clr      (clr),
        .step     (step),
        .cnt      (cnt),
        .cnt_next (cnt_next),
        .load     (load),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: a load pulse pops the next expectation, checked one cycle later.
    initial begin
        armed   = 1'b0;
        n_loads = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                armed = 1'b0;
            end else begin
                if (armed) begin
                    check("cnt_after_load", int'(cnt), int'(pend.cnt));
                    check("wrap_after_load", int'(wrap), int'(pend.wrap));
                    armed = 1'b0;
                end else if (wrap) begin
                    check("spurious_wrap", int'(wrap), 0);
                end
                if (load) begin
                    n_loads++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_load", 1, 0);
                    end else begin
                        pend  = exp_q.pop_front();
                        armed = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick !== 1'b1);
            #2;
        end
    endtask

    task automatic press(input logic [W-1:0] s, input logic d, input logic c,
                         input logic [W-1:0] exp_cnt, input logic exp_wrap);
        int loads0;
        exp_t e;
        wait_ticks(1);
        step = s;
        dir  = d;
        clr  = c;
        #1;
        check("cnt_next", int'(cnt_next), int'(exp_cnt));
        e.cnt  = exp_cnt;
        e.wrap = exp_wrap;
        exp_q.push_back(e);
        loads0 = n_loads;
        btn_in = 1'b1;
        wait_ticks(6);
        btn_in = 1'b0;
        wait_ticks(6);
        check("loads_per_press", n_loads - loads0, 1);
    endtask

    initial begin
        int loads0;
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        btn_in = 1'b1;
        dir    = 1'b0;
        clr    = 1'b0;
        step   = 4'd1;

        // Reset held with button high and ticks running
        for (int i = 0; i < 3; i++) begin
            repeat (4) @(negedge clk);
            check("rst_cnt", int'(cnt), 0);
            check("rst_load", int'(load), 0);
            check("rst_wrap", int'(wrap), 0);
        end
        btn_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ticks(6);
        check("post_rst_cnt", int'(cnt), 0);

        press(4'd1, 1'b0, 1'b0, 4'd1, 1'b0);

        // Bouncing button never holds long enough to qualify
        loads0 = n_loads;
        for (int i = 0; i < 10; i++) begin
            btn_in = ~btn_in;
            wait_ticks(1);
        end
        btn_in = 1'b0;
        wait_ticks(6);
        check("bounce_loads", n_loads - loads0, 0);
        check("bounce_cnt", int'(cnt), 1);

        press(4'd0, 1'b0, 1'b0, 4'd1, 1'b0);
        press(4'd14, 1'b0, 1'b0, 4'd15, 1'b0);
`ifdef BTN_CNT_SAT_EN
        press(4'd3, 1'b0, 1'b0, 4'd15, 1'b1);
`else
        press(4'd3, 1'b0, 1'b0, 4'd2, 1'b1);
`endif
        press(4'd7, 1'b0, 1'b1, 4'd0, 1'b0);
        press(4'd2, 1'b0, 1'b0, 4'd2, 1'b0);
`ifdef BTN_CNT_SAT_EN
        press(4'd5, 1'b1, 1'b0, 4'd0, 1'b1);
`else
        press(4'd5, 1'b1, 1'b0, 4'd13, 1'b1);
`endif
        press(4'd5, 1'b1, 1'b1, 4'd0, 1'b0);
        press(4'd6, 1'b0, 1'b0, 4'd6, 1'b0);

        // Reset three ticks into the press qualification
        loads0 = n_loads;
        wait_ticks(1);
        btn_in = 1'b1;
        wait_ticks(3);
        rst_n  = 1'b0;
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_cnt", int'(cnt), 0);
        check("midrst_load", int'(load), 0);
        check("midrst_state", int'(u_dut.u_pulse_gen.r_state), int'(ST_IDLE));
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ticks(6);
        check("midrst_loads", n_loads - loads0, 0);
        check("midrst_cnt_after", int'(cnt), 0);
        check("midrst_state_after", int'(u_dut.u_pulse_gen.r_state), int'(ST_IDLE));

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_btn_step_counter

`default_nettype wire
